// File: rtl/denotation_pkg.sv
// Shared definitions for the notation/denotation radix converters.
// FSM state encodings, ceiling-log2 and counter-width helpers.
`timescale 1ns/1ps
package denotation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = unsigned'(i + 1);
    end
    return res;
  endfunction

  // Digit counter needs at least one bit even for single-digit conversions
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/denotation_digit_mac.sv
// Combinational Horner step: sum = acc*BASE + digit, wrapped to BIT_DEPTH bits.
// With DENOTATION_OVERFLOW_EN the product is kept wide and a carry-out is produced.
`timescale 1ns/1ps
module denotation_digit_mac
  import denotation_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned BASE      = 10
) (
  input  logic [BIT_DEPTH-1:0] acc,
  input  logic [BIT_DEPTH-1:0] digit,
  output logic [BIT_DEPTH-1:0] sum
`ifdef DENOTATION_OVERFLOW_EN
  ,output logic                carry
`endif
);

`ifdef DENOTATION_OVERFLOW_EN
  localparam int unsigned PROD_W = BIT_DEPTH + clog2(BASE) + 1;

  logic [PROD_W-1:0] full;

  // Wide enough that (2^D-1)*BASE + (2^D-1) never wraps
  assign full  = PROD_W'(acc) * PROD_W'(BASE) + PROD_W'(digit);
  assign sum   = full[BIT_DEPTH-1:0];
  assign carry = |full[PROD_W-1:BIT_DEPTH];
`else
  assign sum = acc * BIT_DEPTH'(BASE) + digit;
`endif

endmodule

// File: rtl/denotation.sv
// Rebuilds a binary number from NUM_DIGITS base-BASE digits, MSD first, one digit per clock.
// Optional sticky overflow flag enabled by defining DENOTATION_OVERFLOW_EN.
`timescale 1ns/1ps
module denotation
  import denotation_pkg::*;
#(
  parameter int unsigned BIT_DEPTH  = 8,
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned BASE       = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_DIGITS*BIT_DEPTH-1:0] digits,
  output logic [BIT_DEPTH-1:0]            number,
  output logic                            busy,
  output logic                            conversion_done,
  output logic                            digit_error
`ifdef DENOTATION_OVERFLOW_EN
  ,output logic                           overflow
`endif
);

  localparam int unsigned DIG_W = NUM_DIGITS * BIT_DEPTH;
  localparam int unsigned CNT_W = cnt_width(NUM_DIGITS);
  localparam int unsigned CMP_W = BIT_DEPTH + 1;

  state_e               state_q, state_d;
  logic [DIG_W-1:0]     shift_q, shift_d;
  logic [BIT_DEPTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_DEPTH-1:0] number_d;
  logic                 busy_d, done_d, err_d;
  logic [BIT_DEPTH-1:0] cur_digit, mac_sum;

  assign cur_digit = shift_q[DIG_W-1 -: BIT_DEPTH];

`ifdef DENOTATION_OVERFLOW_EN
  logic mac_carry;
  logic ovf_d;

  denotation_digit_mac #(.BIT_DEPTH(BIT_DEPTH), .BASE(BASE)) u_mac (
    .acc   (acc_q),
    .digit (cur_digit),
    .sum   (mac_sum),
    .carry (mac_carry)
  );
`else
  denotation_digit_mac #(.BIT_DEPTH(BIT_DEPTH), .BASE(BASE)) u_mac (
    .acc   (acc_q),
    .digit (cur_digit),
    .sum   (mac_sum)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      shift_q         <= '0;
      acc_q           <= '0;
      cnt_q           <= '0;
      number          <= '0;
      busy            <= 1'b0;
      conversion_done <= 1'b0;
      digit_error     <= 1'b0;
`ifdef DENOTATION_OVERFLOW_EN
      overflow        <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      number          <= number_d;
      busy            <= busy_d;
      conversion_done <= done_d;
      digit_error     <= err_d;
`ifdef DENOTATION_OVERFLOW_EN
      overflow        <= ovf_d;
`endif
    end
  end

  // Next-state and next-output logic; busy/done are registered copies of the next state
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    number_d = number;
    busy_d   = busy;
    done_d   = conversion_done;
    err_d    = digit_error;
`ifdef DENOTATION_OVERFLOW_EN
    ovf_d    = overflow;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          shift_d = digits;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef DENOTATION_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          state_d = ST_CONVERT;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_CONVERT: begin
        acc_d   = mac_sum;
        shift_d = shift_q << BIT_DEPTH;
        cnt_d   = cnt_q + CNT_W'(1);
        if (CMP_W'(cur_digit) >= CMP_W'(BASE)) err_d = 1'b1;
`ifdef DENOTATION_OVERFLOW_EN
        if (mac_carry) ovf_d = 1'b1;
`endif
        if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
          number_d = mac_sum;
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_denotation.sv
// Scoreboard bench for denotation: decimal 8-bit/3-digit instance plus binary 4-bit/4-digit instance.
// Overflow checks are active when DENOTATION_OVERFLOW_EN is defined.
`timescale 1ns/1ps
module tb_denotation;

  logic        clk = 1'b0;
  logic        reset, start, bstart;
  logic [23:0] digits;
  logic [15:0] bdigits;
  logic [7:0]  number;
  logic        busy, done, err;
  logic [3:0]  bnumber;
  logic        bbusy, bdone, berr;
`ifdef DENOTATION_OVERFLOW_EN
  logic        ovf8, ovfb;
`endif

  always #5 clk = ~clk;

  denotation #(.BIT_DEPTH(8), .NUM_DIGITS(3), .BASE(10)) u_dut (
    .clk(clk), .reset(reset), .start(start), .digits(digits),
    .number(number), .busy(busy), .conversion_done(done), .digit_error(err)
`ifdef DENOTATION_OVERFLOW_EN
    , .overflow(ovf8)
`endif
  );

  denotation #(.BIT_DEPTH(4), .NUM_DIGITS(4), .BASE(2)) u_bin (
    .clk(clk), .reset(reset), .start(bstart), .digits(bdigits),
    .number(bnumber), .busy(bbusy), .conversion_done(bdone), .digit_error(berr)
`ifdef DENOTATION_OVERFLOW_EN
    , .overflow(ovfb)
`endif
  );

  typedef struct {
    int num;
    bit err;
    bit ovf;
  } exp_t;

  exp_t q8[$];
  exp_t qb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the decimal instance: compare on each rising conversion_done
  logic prev8 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !prev8) begin
      if (q8.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb8_unexpected: got number %0d with no expected entry", number);
      end else begin
        e = q8.pop_front();
        chk("sb8_number", int'(number), e.num);
        chk("sb8_digit_error", int'(err), int'(e.err));
`ifdef DENOTATION_OVERFLOW_EN
        chk("sb8_overflow", int'(ovf8), int'(e.ovf));
`endif
      end
    end
    prev8 = done;
  end

  // Monitor for the binary instance
  logic prevb = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bdone && !prevb) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sbb_unexpected: got number %0d with no expected entry", bnumber);
      end else begin
        e = qb.pop_front();
        chk("sbb_number", int'(bnumber), e.num);
        chk("sbb_digit_error", int'(berr), int'(e.err));
`ifdef DENOTATION_OVERFLOW_EN
        chk("sbb_overflow", int'(ovfb), int'(e.ovf));
`endif
      end
    end
    prevb = bdone;
  end

  task automatic wait_done8(output int cyc, output int busy_cycles);
    cyc = 0;
    busy_cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) busy_cycles++;
    end while (!done && cyc < 20);
  endtask

  task automatic run8(input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0,
                      input int en, input bit ee, input bit eo);
    int cyc, bc;
    @(negedge clk);
    digits = {d2, d1, d0};
    start  = 1'b1;
    q8.push_back('{num: en, err: ee, ovf: eo});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("done_cleared_at_start", int'(done), 0);
    chk("err_cleared_at_start", int'(err), 0);
    wait_done8(cyc, bc);
    chk("done_latency", cyc, 3);
    chk("busy_cycles_after_start", bc, 2);
  endtask

  task automatic runb(input logic [15:0] d, input int en, input bit ee, input bit eo);
    int cyc;
    @(negedge clk);
    bdigits = d;
    bstart  = 1'b1;
    qb.push_back('{num: en, err: ee, ovf: eo});
    @(posedge clk);
    #1;
    bstart = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bdone && cyc < 20);
    chk("b_done_latency", cyc, 4);
  endtask

  initial begin
    int cyc, bc;
    reset   = 1'b1;
    start   = 1'b0;
    bstart  = 1'b0;
    digits  = '0;
    bdigits = '0;
    #12;
    chk("rst_number", int'(number), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
`ifdef DENOTATION_OVERFLOW_EN
    chk("rst_overflow", int'(ovf8), 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    run8(8'd1, 8'd2, 8'd3, 123, 1'b0, 1'b0);
    run8(8'd2, 8'd5, 8'd5, 255, 1'b0, 1'b0);
    run8(8'd2, 8'd5, 8'd6, 0,   1'b0, 1'b1);
    run8(8'd1, 8'd10, 8'd0, 200, 1'b1, 1'b0);
    run8(8'd0, 8'd0, 8'd7, 7,   1'b0, 1'b0);

    // Abort a conversion after its second CONVERT edge
    @(negedge clk);
    digits = {8'd9, 8'd9, 8'd9};
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_number", int'(number), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err), 0);
    @(negedge clk);
    reset = 1'b0;
    run8(8'd0, 8'd4, 8'd2, 42, 1'b0, 1'b0);

    // Round trip over every 8-bit value with start held high
    @(negedge clk);
    start = 1'b1;
    for (int v = 0; v < 256; v++) begin
      digits = {8'(v / 100), 8'((v / 10) % 10), 8'(v % 10)};
      q8.push_back('{num: v, err: 1'b0, ovf: 1'b0});
      @(posedge clk);
      #1;
      wait_done8(cyc, bc);
      chk("rt_latency", cyc, 3);
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rt_done_held", int'(done), 1);
    chk("rt_number_held", int'(number), 255);

    runb(16'h1010, 10, 1'b0, 1'b0);
    runb(16'h0110, 6,  1'b0, 1'b0);
    runb(16'h0021, 5,  1'b1, 1'b0);
    runb(16'hF000, 8,  1'b1, 1'b1);

    repeat (5) @(negedge clk);
    chk("sb8_drained", q8.size(), 0);
    chk("sbb_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
